// File: rtl/fetch_queue.sv
// fetch_queue: decoupling instruction queue between fetch and decode.
// Holds {pc, pc4, inst, predict_taken} entries in a DEPTH-entry ring buffer
// and presents the oldest one to decode through a valid/ready handshake.
// A flush discards every queued wrong-path entry.
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN
//   When defined, an entry arriving at an empty queue is forwarded to decode
//   in the same cycle; if decode takes it, it is never written to storage.
//   When undefined, an entry is visible to decode one cycle after it is
//   enqueued, and there is no combinational path from enq_* to deq_*.

module fetch_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    flush,

    input  logic                    enq_valid,
    output logic                    enq_ready,
    input  logic [DATA_WIDTH-1:0]   enq_pc,
    input  logic [DATA_WIDTH-1:0]   enq_pc4,
    input  logic [31:0]             enq_inst,
    input  logic                    enq_predict_taken,

    output logic                    deq_valid,
    input  logic                    deq_ready,
    output logic [DATA_WIDTH-1:0]   deq_pc,
    output logic [DATA_WIDTH-1:0]   deq_pc4,
    output logic [31:0]             deq_inst,
    output logic                    deq_predict_taken,

    output logic [$clog2(DEPTH):0]  count
);

    localparam int          IDX_W = $clog2(DEPTH);
    localparam int          PTR_W = IDX_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [IDX_W-1:0]       wr_idx;
    logic [IDX_W-1:0]       rd_idx;

    logic [DATA_WIDTH-1:0]  pc_mem   [DEPTH];
    logic [DATA_WIDTH-1:0]  pc4_mem  [DEPTH];
    logic [31:0]            inst_mem [DEPTH];
    logic [DEPTH-1:0]       pt_mem;

    logic                   empty;
    logic                   full;
    logic                   bypass;
    logic                   bypass_take;
    logic                   enq_fire;
    logic                   deq_fire;
    logic                   mem_write;
    logic                   rd_advance;

    logic [DATA_WIDTH-1:0]  head_pc;
    logic [DATA_WIDTH-1:0]  head_pc4;
    logic [31:0]            head_inst;
    logic                   head_pt;

    assign wr_idx = wr_ptr[IDX_W-1:0];
    assign rd_idx = rd_ptr[IDX_W-1:0];

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_idx == rd_idx) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty & enq_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif

    // enq_ready depends only on occupancy, never on deq_ready
    assign enq_ready   = ~full;
    assign deq_valid   = (~empty & ~flush) | bypass;

    assign enq_fire    = enq_valid & enq_ready & ~flush;
    assign deq_fire    = deq_valid & deq_ready;
    assign bypass_take = bypass & deq_ready;
    assign mem_write   = enq_fire & ~bypass_take;
    assign rd_advance  = deq_fire & ~bypass;

    // Occupancy is the modulo-2*DEPTH pointer distance, always 0..DEPTH
    assign count = wr_ptr - rd_ptr;

    // Head selection: forwarded enq entry while bypassing, else the oldest slot
    always_comb begin
        head_pc   = pc_mem[rd_idx];
        head_pc4  = pc4_mem[rd_idx];
        head_inst = inst_mem[rd_idx];
        head_pt   = pt_mem[rd_idx];
        if (bypass) begin
            head_pc   = enq_pc;
            head_pc4  = enq_pc4;
            head_inst = enq_inst;
            head_pt   = enq_predict_taken;
        end
    end

    assign deq_pc            = head_pc;
    assign deq_pc4           = head_pc4;
    assign deq_inst          = deq_valid ? head_inst : NOP;
    assign deq_predict_taken = deq_valid & head_pt;

    // Pointer update: flush collapses the queue to empty, otherwise advance on fire
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (mem_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_advance) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Entry storage: cleared on reset, written at the tail on an accepted enq
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                pc4_mem[i]  <= '0;
                inst_mem[i] <= '0;
            end
            pt_mem <= '0;
        end else if (mem_write) begin
            pc_mem[wr_idx]   <= enq_pc;
            pc4_mem[wr_idx]  <= enq_pc4;
            inst_mem[wr_idx] <= enq_inst;
            pt_mem[wr_idx]   <= enq_predict_taken;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue.
// Directed scenarios followed by a randomized phase, all compared every cycle
// against a queue-based reference model. Honours FETCH_QUEUE_BYPASS_EN.

module tb_fetch_queue;

    localparam int          DATA_WIDTH = 32;
    localparam int          DEPTH      = 4;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic                   clk;
    logic                   arst_n;
    logic                   flush;
    logic                   enq_valid;
    logic                   enq_ready;
    logic [DATA_WIDTH-1:0]  enq_pc;
    logic [DATA_WIDTH-1:0]  enq_pc4;
    logic [31:0]            enq_inst;
    logic                   enq_predict_taken;
    logic                   deq_valid;
    logic                   deq_ready;
    logic [DATA_WIDTH-1:0]  deq_pc;
    logic [DATA_WIDTH-1:0]  deq_pc4;
    logic [31:0]            deq_inst;
    logic                   deq_predict_taken;
    logic [$clog2(DEPTH):0] count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        pt;
    } entry_t;

    entry_t mq[$];

    int passCount;
    int failCount;
    int totalCount;

    fetch_queue #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) dut (
        .clk               (clk),
        .arst_n            (arst_n),
        .flush             (flush),
        .enq_valid         (enq_valid),
        .enq_ready         (enq_ready),
        .enq_pc            (enq_pc),
        .enq_pc4           (enq_pc4),
        .enq_inst          (enq_inst),
        .enq_predict_taken (enq_predict_taken),
        .deq_valid         (deq_valid),
        .deq_ready         (deq_ready),
        .deq_pc            (deq_pc),
        .deq_pc4           (deq_pc4),
        .deq_inst          (deq_inst),
        .deq_predict_taken (deq_predict_taken),
        .count             (count)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic ev, input logic [31:0] pc, input logic dr, input logic fl);
        enq_valid         = ev;
        enq_pc            = pc;
        enq_pc4           = pc + 32'd4;
        enq_inst          = $urandom;
        enq_predict_taken = 1'($urandom_range(0, 1));
        deq_ready         = dr;
        flush             = fl;
    endtask

    function automatic logic modelBypass();
        logic b;
        b = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        b = (mq.size() == 0) && enq_valid && !flush;
`endif
        return b;
    endfunction

    // Compare every output against what the reference queue predicts
    task automatic checkAll();
        logic   isEmpty;
        logic   isFull;
        logic   byp;
        logic   expValid;
        entry_t h;
        isEmpty  = (mq.size() == 0);
        isFull   = (mq.size() == DEPTH);
        byp      = modelBypass();
        expValid = (!isEmpty && !flush) || byp;
        h.pc = '0; h.pc4 = '0; h.inst = NOP; h.pt = 1'b0;
        if (byp) begin
            h.pc = enq_pc; h.pc4 = enq_pc4; h.inst = enq_inst; h.pt = enq_predict_taken;
        end else if (!isEmpty) begin
            h = mq[0];
        end
        checkOutput("deq_valid", 32'(deq_valid), 32'(expValid));
        checkOutput("enq_ready", 32'(enq_ready), 32'(!isFull));
        checkOutput("count", 32'(count), 32'(mq.size()));
        if (expValid) begin
            checkOutput("deq_pc", deq_pc, h.pc);
            checkOutput("deq_pc4", deq_pc4, h.pc4);
            checkOutput("deq_inst", deq_inst, h.inst);
            checkOutput("deq_pt", 32'(deq_predict_taken), 32'(h.pt));
        end else begin
            checkOutput("deq_inst_nop", deq_inst, NOP);
            checkOutput("deq_pt_zero", 32'(deq_predict_taken), 32'd0);
        end
    endtask

    // Reference behaviour at a clock edge, using the inputs held across it
    task automatic modelUpdate();
        logic   byp;
        logic   expValid;
        logic   doEnq;
        logic   doDeq;
        entry_t e;
        if (flush) begin
            mq.delete();
        end else begin
            byp      = modelBypass();
            expValid = (mq.size() != 0) || byp;
            doDeq    = expValid && deq_ready;
            doEnq    = enq_valid && (mq.size() < DEPTH);
            e.pc = enq_pc; e.pc4 = enq_pc4; e.inst = enq_inst; e.pt = enq_predict_taken;
            if (!(byp && doDeq)) begin
                if (doDeq) void'(mq.pop_front());
                if (doEnq) mq.push_back(e);
            end
        end
    endtask

    // One cycle: check at the negedge, step the model at the posedge
    task automatic cycle();
        #4;
        checkAll();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_deq_valid"}, 32'(deq_valid), 32'd0);
        checkOutput({tag, "_enq_ready"}, 32'(enq_ready), 32'd1);
        checkOutput({tag, "_count"}, 32'(count), 32'd0);
        checkOutput({tag, "_deq_inst"}, deq_inst, NOP);
        checkOutput({tag, "_deq_pc"}, deq_pc, 32'd0);
        checkOutput({tag, "_deq_pc4"}, deq_pc4, 32'd0);
        checkOutput({tag, "_deq_pt"}, 32'(deq_predict_taken), 32'd0);
    endtask

    initial begin
        passCount  = 0;
        failCount  = 0;
        totalCount = 0;

        // Reset and idle
        arst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checkResetValues("reset");
        #11;
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cycle();

        // Fill to DEPTH with decode stalled, offer a fifth entry, then drain
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'(i * 4), 1'b0, 1'b0);
            cycle();
        end
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0);
        cycle();
        checkOutput("full_count", 32'(count), 32'd4);
        checkOutput("full_enq_ready", 32'(enq_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
            cycle();
        end
        checkOutput("drained_count", 32'(count), 32'd0);

        // Streaming enq+deq across several pointer wraps
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(i * 4), 1'b1, 1'b0);
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
            cycle();
        end

        // Flush with three entries queued and an enq in the flush cycle
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h180 + 32'(i * 4), 1'b0, 1'b0);
            cycle();
        end
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b1);
        cycle();
        checkOutput("post_flush_count", 32'(count), 32'd0);
        applyStimulus(1'b1, 32'h300, 1'b1, 1'b0);
        cycle();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
            cycle();
        end

        // Enq into an empty queue with decode ready (bypass or 1-cycle latency)
        applyStimulus(1'b1, 32'h40, 1'b1, 1'b0);
        cycle();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
            cycle();
        end

        // Asynchronous reset mid-drain with two entries held
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h500 + 32'(i * 4), 1'b0, 1'b0);
            cycle();
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        cycle();
        checkOutput("pre_reset_count", 32'(count), 32'd2);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        arst_n = 1'b0;
        #2;
        mq.delete();
        checkResetValues("async_reset");
        #1;
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0),
                          $urandom & 32'hFFFF_FFFC,
                          1'($urandom_range(0, 2) != 0) ^ (i >= 200 && i < 260),
                          1'($urandom_range(0, 24) == 0));
            cycle();
        end

        $display("[TB] %0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
